// File: rtl/iic_target.sv
// I2C target endpoint: oversampled START/STOP detection, write-byte strobes
// and read bytes served from a core-supplied register.
module iic_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rw
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_WRITE     = 3'd3,
        S_WRITE_ACK = 3'd4,
        S_READ      = 3'd5,
        S_READ_ACK  = 3'd6,
        S_IGNORE    = 3'd7
    } state_t;

    state_t     state, state_nx;
    logic [7:0] shreg, shreg_nx;
    logic [3:0] bit_cnt, cnt_nx;
    logic       drive, drive_nx;
    logic [7:0] rx_data_nx;
    logic       rx_valid_nx, tx_req_nx, busy_nx, rw_nx;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;
    logic rise, fall, start, stop;

    // Open-drain: only ever pull low
    assign sda = drive ? 1'b0 : 1'bz;

    always_ff @(posedge clock) begin
        if (reset) begin
            {scl_s1, scl_s2, scl_h} <= 3'b111;
            {sda_s1, sda_s2, sda_h} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_h} <= {scl, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_h} <= {sda, sda_s1, sda_s2};
        end
    end

    assign rise  = scl_s2 & ~scl_h;
    assign fall  = ~scl_s2 & scl_h;
    assign start = scl_s2 & sda_h & ~sda_s2;
    assign stop  = scl_s2 & ~sda_h & sda_s2;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            shreg    <= 8'd0;
            bit_cnt  <= 4'd0;
            drive    <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            rw       <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bit_cnt  <= cnt_nx;
            drive    <= drive_nx;
            rx_data  <= rx_data_nx;
            rx_valid <= rx_valid_nx;
            tx_req   <= tx_req_nx;
            busy     <= busy_nx;
            rw       <= rw_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        cnt_nx      = bit_cnt;
        drive_nx    = drive;
        rx_data_nx  = rx_data;
        rx_valid_nx = 1'b0;
        tx_req_nx   = 1'b0;
        busy_nx     = busy;
        rw_nx       = rw;
        if (stop) begin
            state_nx = S_IDLE;
            drive_nx = 1'b0;
            busy_nx  = 1'b0;
            cnt_nx   = 4'd0;
        end else if (start) begin
            state_nx = S_ADDR;
            drive_nx = 1'b0;
            busy_nx  = 1'b0;
            cnt_nx   = 4'd0;
        end else begin
            unique case (state)
                S_IDLE: drive_nx = 1'b0;
                S_ADDR: begin
                    if (bit_cnt == 4'd8) begin
                        if (shreg[7:1] != ADDR) begin
                            state_nx = S_IGNORE;
                            drive_nx = 1'b0;
                        end else if (fall) begin
                            state_nx = S_ADDR_ACK;
                            drive_nx = 1'b1;
                            rw_nx    = shreg[0];
                            busy_nx  = 1'b1;
                        end
                    end else if (rise) begin
                        shreg_nx = {shreg[6:0], sda_s2};
                        cnt_nx   = bit_cnt + 4'd1;
                    end
                end
                S_ADDR_ACK: begin
                    if (rise && rw) begin
                        tx_req_nx = 1'b1;
                    end else if (fall) begin
                        if (rw) begin
                            state_nx = S_READ;
                            shreg_nx = tx_data;
                            drive_nx = ~tx_data[7];
                            cnt_nx   = 4'd1;
                        end else begin
                            state_nx = S_WRITE;
                            drive_nx = 1'b0;
                            cnt_nx   = 4'd0;
                        end
                    end
                end
                S_WRITE: begin
                    if (rise && bit_cnt != 4'd8) begin
                        shreg_nx = {shreg[6:0], sda_s2};
                        cnt_nx   = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_data_nx  = {shreg[6:0], sda_s2};
                            rx_valid_nx = 1'b1;
                        end
                    end else if (fall && bit_cnt == 4'd8) begin
                        state_nx = S_WRITE_ACK;
                        drive_nx = 1'b1;
                    end
                end
                S_WRITE_ACK: begin
                    if (fall) begin
                        state_nx = S_WRITE;
                        drive_nx = 1'b0;
                        cnt_nx   = 4'd0;
                    end
                end
                S_READ: begin
                    if (fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nx = S_READ_ACK;
                            drive_nx = 1'b0;
                        end else begin
                            shreg_nx = {shreg[6:0], 1'b0};
                            drive_nx = ~shreg[6];
                            cnt_nx   = bit_cnt + 4'd1;
                        end
                    end
                end
                S_READ_ACK: begin
                    if (rise) begin
                        if (!sda_s2) begin
                            tx_req_nx = 1'b1;
                        end else begin
                            state_nx = S_IGNORE;
                            busy_nx  = 1'b0;
                            drive_nx = 1'b0;
                        end
                    end else if (fall) begin
                        state_nx = S_READ;
                        shreg_nx = tx_data;
                        drive_nx = ~tx_data[7];
                        cnt_nx   = 4'd1;
                    end
                end
                S_IGNORE: drive_nx = 1'b0;
                default: begin
                    state_nx = S_IDLE;
                    drive_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_target.sv
// Bench for iic_target: bit-banged I2C master with scoreboard queues
// for received write bytes and served read bytes.
module tb_iic_target;

    localparam int Q = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;
    logic       rw;

    int n_chk = 0;
    int n_fail = 0;
    int n_rx = 0;
    int n_txreq = 0;
    bit dut_drv = 0;
    bit busy_seen = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_rd[$];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    iic_target #(.ADDR(7'h50)) dut (
        .clock(clock), .reset(reset), .scl(scl), .sda(sda),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_req(tx_req), .busy(busy), .rw(rw)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop expected write bytes, feed read bytes
    always @(negedge clock) begin
        if (!m_low && sda === 1'b0) dut_drv = 1;
        if (busy) busy_seen = 1;
        if (rx_valid) begin
            n_rx++;
            if (exp_rx.size() == 0) check("rx_unexp", rx_valid, 0);
            else check("rx_data", rx_data, exp_rx.pop_front());
        end
        if (tx_req) begin
            n_txreq++;
            if (tx_q.size() == 0) begin
                check("tx_unexp", tx_req, 0);
            end else begin
                tx_data = tx_q.pop_front();
                exp_rd.push_back(tx_data);
            end
        end
    end

    task automatic wq(input int n);
        repeat (n * Q) @(negedge clock);
    endtask

    task automatic m_start();
        m_low = 0; wq(1);
        scl = 1;   wq(1);
        m_low = 1; wq(1);
        scl = 0;   wq(1);
    endtask

    task automatic m_stop();
        m_low = 1; wq(1);
        scl = 1;   wq(1);
        m_low = 0; wq(1);
    endtask

    task automatic m_wbit(input logic b);
        m_low = ~b; wq(1);
        scl = 1;    wq(2);
        scl = 0;    wq(1);
    endtask

    task automatic m_rbit(output logic b);
        m_low = 0; wq(1);
        scl = 1;   wq(1);
        b = (sda !== 1'b0);
        wq(1);
        scl = 0;   wq(1);
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) m_wbit(d[i]);
        m_rbit(ack);
    endtask

    task automatic m_rbyte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            m_rbit(b);
            d[i] = b;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0;

        repeat (4) @(negedge clock);
        reset = 0;
        @(negedge clock);
        check("rst_sda", sda, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_busy", busy, 0);
        check("rst_rw", rw, 0);
        check("rst_state", dut.state, 0);

        // Write two bytes
        wq(2);
        exp_rx.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        m_start();
        m_wbyte(8'hA0, ack); check("wr_addr_ack", ack, 0);
        check("wr_rw", rw, 0);
        check("wr_busy", busy, 1);
        m_wbyte(8'hA5, ack); check("wr_ack1", ack, 0);
        m_wbyte(8'h3C, ack); check("wr_ack2", ack, 0);
        m_stop();
        wq(1);
        check("wr_busy_end", busy, 0);
        check("wr_rx_left", exp_rx.size(), 0);
        check("wr_rx_cnt", n_rx, 2);

        // Wrong address
        dut_drv = 0; busy_seen = 0; rx0 = n_rx;
        m_start();
        m_wbyte(8'hA2, ack); check("wa_addr_nack", ack, 1);
        m_wbyte(8'h77, ack); check("wa_data_nack", ack, 1);
        m_stop();
        wq(1);
        check("wa_driven", dut_drv, 0);
        check("wa_busy", busy_seen, 0);
        check("wa_rx", n_rx, rx0);

        // Read two bytes, ACK then NACK
        n_txreq = 0;
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'h81);
        m_start();
        m_wbyte(8'hA1, ack); check("rd_addr_ack", ack, 0);
        check("rd_rw", rw, 1);
        m_rbyte(d);
        check("rd_byte1", d, exp_rd.size() ? exp_rd.pop_front() : 8'hxx);
        m_wbit(1'b0);
        m_rbyte(d);
        check("rd_byte2", d, exp_rd.size() ? exp_rd.pop_front() : 8'hxx);
        m_wbit(1'b1);
        wq(1);
        check("rd_state_ign", dut.state, 7);
        check("rd_busy_nack", busy, 0);
        m_stop();
        wq(1);
        check("rd_state_idle", dut.state, 0);
        check("rd_txreq_cnt", n_txreq, 2);

        // Write then repeated START into a read
        exp_rx.push_back(8'h10);
        tx_q.push_back(8'h5A);
        m_start();
        m_wbyte(8'hA0, ack); check("rs_wr_ack", ack, 0);
        m_wbyte(8'h10, ack); check("rs_data_ack", ack, 0);
        m_start();
        m_wbyte(8'hA1, ack); check("rs_rd_ack", ack, 0);
        check("rs_rw", rw, 1);
        m_rbyte(d);
        check("rs_byte", d, exp_rd.size() ? exp_rd.pop_front() : 8'hxx);
        m_wbit(1'b1);
        m_stop();
        wq(1);
        check("rs_rx_data", rx_data, 8'h10);

        // Abort mid-byte with STOP
        rx0 = n_rx;
        m_start();
        m_wbyte(8'hA0, ack); check("ab_addr_ack", ack, 0);
        m_wbit(1); m_wbit(0); m_wbit(1); m_wbit(1);
        m_stop();
        wq(1);
        check("ab_rx", n_rx, rx0);
        check("ab_sda", sda, 1);
        check("ab_state", dut.state, 0);
        check("ab_busy", busy, 0);

        // Reset during address ACK
        m_start();
        for (int i = 7; i >= 0; i--) m_wbit(i == 5 || i == 7);
        m_low = 0;
        repeat (Q) @(negedge clock);
        check("rs_ack_low", sda, 0);
        reset = 1;
        @(negedge clock);
        check("rr_sda", sda, 1);
        check("rr_busy", busy, 0);
        check("rr_rx_data", rx_data, 0);
        check("rr_rw", rw, 0);
        check("rr_state", dut.state, 0);
        reset = 0;
        wq(1);
        scl = 1;
        wq(2);
        m_start();
        m_wbyte(8'hA0, ack); check("rr_addr_ack", ack, 0);
        m_stop();
        wq(1);
        check("rr_busy_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
